// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } prio_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating conflict-streak counter and the priority state it drives.
// force_i is high for one conflict after STARVE_MAX consecutive data wins.
`timescale 1ns/1ps
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic conflict,
    input  logic i_gnt,
    input  logic i_req,
    output logic force_i
);

    localparam logic [3:0] MAX = 4'(STARVE_MAX);

    prio_state_t state;
    logic [3:0]  streak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= PRIO_D;
            streak <= 4'd0;
        end else if (!i_req || i_gnt) begin
            state  <= PRIO_D;
            streak <= 4'd0;
        end else if (conflict && state == PRIO_D) begin
            if (streak != MAX) begin
                streak <= streak + 4'd1;
            end
            // This conflict is the last one D may win before I is forced through.
            if (streak >= MAX - 4'd1) begin
                state <= PRIO_I;
            end
        end
    end

    assign force_i = (state == PRIO_I);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and data (D).
// Handshake: a requester holds req/addr until gnt; gnt is a same-cycle accept and the response follows one cycle later.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_out
);

    logic conflict;
    logic force_i;
    logic d_misalign;

    assign conflict   = i_req & d_req;
    assign d_misalign = (d_addr[1:0] & WORD_ALIGN_MASK) != 2'b00;

    // D wins every conflict except when the starvation bound forces I through.
    assign d_gnt = ~rst & d_req & ~(i_req & force_i);
    assign i_gnt = ~rst & i_req & ~(d_req & ~force_i);

    assign mem_a  = d_gnt ? d_addr : i_addr;
    assign mem_wd = d_gnt ? d_wdata : '0;
    assign mem_we = d_gnt & d_we & ~d_misalign;

    mem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .conflict(conflict),
        .i_gnt   (i_gnt),
        .i_req   (i_req),
        .force_i (force_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            i_rvalid <= i_gnt;
            d_rvalid <= d_gnt;
            d_err    <= d_gnt & d_misalign;
            if (i_gnt) begin
                i_rdata <= mem_out;
            end
            // Writes and faulting accesses return zero rather than stale memory contents.
            if (d_gnt) begin
                d_rdata <= (d_we || d_misalign) ? '0 : mem_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a behavioural arbitration/memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_out;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_out(mem_out)
    );

    // clock / memory environment
    always #5 clk = ~clk;

    logic [31:0] ram [0:63];
    assign mem_out = ram[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_we) ram[mem_a[7:2]] <= mem_wd;
    end

    // scoreboard state
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [0:63];
    logic [31:0] exp_q   [$];
    logic [32:0] exp_d_q [$];
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
    int          i_wait = 0;
    int          stall = 0;
    int          max_stall = 0;
    logic        i_done = 1'b0;
    logic        d_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: I may be stalled by D at most STARVE consecutive cycles.
    always @(negedge clk) begin
        logic        ex_i, ex_d, aligned, exp_v, exp_err;
        logic [32:0] dr;
        if (rst) begin
            exp_q.delete();
            exp_d_q.delete();
            last_i = '0;
            last_d = '0;
            i_wait = 0;
            stall  = 0;
            i_done = 1'b0;
            d_done = 1'b0;
            check("rst_i_gnt", i_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_i_rvalid", i_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
        end else begin
            exp_v = (exp_q.size() != 0);
            check("i_rvalid", i_rvalid, exp_v);
            if (exp_v) last_i = exp_q.pop_front();
            check("i_rdata", i_rdata, last_i);

            exp_v   = (exp_d_q.size() != 0);
            exp_err = 1'b0;
            if (exp_v) begin
                dr      = exp_d_q.pop_front();
                exp_err = dr[32];
                last_d  = dr[31:0];
            end
            check("d_rvalid", d_rvalid, exp_v);
            check("d_err", d_err, exp_err);
            check("d_rdata", d_rdata, last_d);

            ex_d    = d_req && !(i_req && i_wait >= STARVE);
            ex_i    = i_req && !ex_d;
            aligned = (d_addr[1:0] == 2'b00);
            check("i_gnt", i_gnt, ex_i);
            check("d_gnt", d_gnt, ex_d);
            check("mem_we", mem_we, ex_d && d_we && aligned);
            if (ex_d) check("mem_a_d", mem_a, d_addr);
            if (ex_d && d_we) check("mem_wd", mem_wd, d_wdata);
            if (ex_i) check("mem_a_i", mem_a, i_addr);

            i_wait = (i_req && !ex_i) ? i_wait + 1 : 0;
            if (ex_i) exp_q.push_back(model_mem[i_addr[7:2]]);
            if (ex_d) begin
                exp_d_q.push_back({!aligned, (d_we || !aligned) ? 32'h0 : model_mem[d_addr[7:2]]});
                if (d_we && aligned) model_mem[d_addr[7:2]] = d_wdata;
            end
            i_done = ex_i;
            d_done = ex_d;

            stall = (i_req && !i_gnt) ? stall + 1 : 0;
            if (stall > max_stall) max_stall = stall;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        for (int k = 0; k < 64; k++) begin
            v = $urandom;
            ram[k] = v;
            model_mem[k] = v;
        end
        ram[4] = 32'hDEADBEEF;
        model_mem[4] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        step();

        // lone fetch read
        i_req = 1'b1; i_addr = 16'h0010;
        step();
        i_req = 1'b0;
        check("lone_i_rvalid", i_rvalid, 1);
        check("lone_i_rdata", i_rdata, 32'hDEADBEEF);
        check("lone_d_rdata", d_rdata, 0);
        step();

        // write then read same address
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h12345678;
        step();
        d_we = 1'b0;
        check("wr_ram", ram[8], 32'h12345678);
        step();
        idle_reqs();
        check("rd_after_wr", d_rdata, 32'h12345678);
        check("rd_after_wr_err", d_err, 0);
        step();

        // continuous conflict: D,D,D,D,I pattern
        max_stall = 0;
        i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0044;
        repeat (15) step();
        idle_reqs();
        check("starve_bound", max_stall, STARVE);
        step();

        // misaligned read then misaligned write
        v = ram[9];
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0023;
        step();
        check("mis_rd_err", d_err, 1);
        check("mis_rd_data", d_rdata, 0);
        d_we = 1'b1; d_addr = 16'h0027; d_wdata = 32'hA5A5A5A5;
        step();
        idle_reqs();
        check("mis_wr_untouched", ram[9], v);
        step();

        // reset while a data grant is open
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
        @(negedge clk);
        #1 rst = 1'b1;
        idle_reqs();
        @(posedge clk);
        #1 check("rst_drop_rvalid", d_rvalid, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        check("rst_rvalid_after", d_rvalid, 0);
        check("fsm_after_rst", dut.u_starve.state, PRIO_D);
        i_req = 1'b1; i_addr = 16'h0008; d_req = 1'b1; d_addr = 16'h000C;
        #1 check("first_conflict_d", d_gnt, 1);
        step();
        idle_reqs();
        step();
        step();

        // idle with held fetch data
        v = i_rdata;
        repeat (3) step();
        check("idle_i_rdata_hold", i_rdata, v);

        // randomized traffic
        max_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_req || i_done) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = 16'($urandom_range(0, 255));
            end
            if (!d_req || d_done) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 63) * 4);
                if ($urandom_range(0, 7) == 0) d_addr[1:0] = 2'($urandom_range(1, 3));
                d_wdata = $urandom;
            end
            step();
        end
        idle_reqs();
        step();
        step();
        check("rand_starve_bound", (max_stall <= STARVE), 1);
        for (int k = 0; k < 64; k++) check("final_mem", ram[k], model_mem[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port, word-addressed unified memory between the pipeline's instruction-fetch (I) requester and the MEM-stage data (D) requester. It grants at most one access per cycle, drives the memory address, write-enable and write-data lines, and returns registered read data one cycle later. The loser is stalled. Data accesses have priority, and a starvation counter bounds instruction-fetch stalls.

## Interface
- ADDR_W, 16, byte address width presented to memory
- DATA_W, 32, word width
- STARVE_MAX, 4, consecutive conflicting D grants allowed before I is forced through (1..15)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until granted
- i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid, one-cycle pulse
- i_rdata  out  DATA_W  fetch data, held until next I response
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data byte address, must be word aligned
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  data response pulse, for both reads and writes
- d_rdata  out  DATA_W  read data; 0 for write or error responses
- d_err  out  1  misaligned data access, pulses together with d_rvalid
- mem_a  out  ADDR_W  memory byte address
- mem_we  out  1  memory write enable
- mem_wd  out  DATA_W  memory write data
- mem_out  in  DATA_W  memory combinational read data

## Operation
- Priority FSM has two states: PRIO_D (reset state) and PRIO_I.
- Conflict means i_req and d_req are both high in the same cycle.
- No conflict: the single requester is granted. When neither requests, there is no grant and mem_we = 0.
- In PRIO_D on a conflict, D is granted and streak increments.
  - When streak reaches STARVE_MAX, the next state is PRIO_I.
- In PRIO_I on a conflict, I is granted, streak clears, and the next state is PRIO_D.
- Any cycle with i_gnt, or with i_req low, clears streak and returns to PRIO_D.
- Address mux:
  - mem_a = d_addr when d_gnt, else i_addr.
  - mem_wd = d_wdata when d_gnt, else 0.
- mem_we = d_gnt & d_we & (d_addr[1:0] == 0) & ~rst.
- Misaligned D access:
  - Still granted and consumed.
  - Memory is not written.
  - d_err = 1 and d_rdata = 0 in the response cycle.
- Read data for the granted port is captured from mem_out at the grant cycle's clock edge.
- Streak counter width is 4 bits and saturates at STARVE_MAX; it never wraps.

## Timing
- Grant latency is 0 cycles: a grant is asserted in the same cycle as the request when that requester wins.
- Response latency is 1 cycle: rvalid and rdata register at the posedge closing the grant cycle.
- Back-to-back grants to the same port give back-to-back rvalid pulses.
- Write then read to the same address in consecutive cycles returns the new data, because memory writes at that same edge.
- Reset values, asserted asynchronously:
  - All rvalid, err and rdata registers = 0.
  - FSM = PRIO_D, streak = 0.
  - Grants and mem_we are forced 0 while rst is high.
- Reset mid-operation: any response pending from the grant cycle is dropped, with no rvalid after reset release.
- Requesters must hold req and address stable until granted. The arbiter keeps no request queue.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W, DATA_W and STARVE_MAX defaults.
  - prio_state_t enum {PRIO_D, PRIO_I}.
  - Helper constant WORD_ALIGN_MASK = 2'b11.
- Sub-module mem_arb_starve_ctr holds the saturating streak counter and the PRIO_D/PRIO_I state.
  - Inputs: conflict, i_gnt, i_req.
  - Output: force_i.
- The top level contains the grant logic, address/data mux and response registers.

## Test plan
- Lone I read at 0x0010 with mem[4] = 0xDEADBEEF → i_gnt same cycle; i_rvalid = 1 and i_rdata = 0xDEADBEEF next cycle; d_* outputs all 0.
- D write of 0x12345678 to 0x0020, then D read of 0x0020 → mem_we = 1 for one cycle; second response d_rdata = 0x12345678, d_err = 0.
- Continuous conflict, STARVE_MAX = 4 → grant pattern D,D,D,D,I repeating; I never waits more than 4 cycles.
- D read at 0x0023 (misaligned) → d_gnt = 1, mem_we = 0, memory unchanged; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
- Assert rst in the cycle after a D grant → d_rvalid stays 0; after release, FSM is PRIO_D and the first conflict grants D.
- I and D idle for 3 cycles → no grants, no rvalid, mem_we = 0; i_rdata retains its last value.
